hr_dpwm_seq: RTL and testbench

Sequencer and configuration controller for the high-resolution DPWM core. It accepts duty-cycle and dead-time requests from the compensator over a valid/ready handshake and holds them in a shadow register. It applies them only at switching-period boundaries, with soft-start ramping, soft-stop ramp-down and a latched fault shutdown. It drives the core's `H_on`, `L_on` and `DeadTime` configuration inputs.

---
 rtl/hr_dpwm_seq.sv | 208 ++++++++++++++++++++
 tb/tb_hr_dpwm_seq.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hr_dpwm_seq.sv
// hr_dpwm_seq: period-synchronous configuration sequencer for the HR DPWM core.
// It holds one shadowed duty/dead-time request. At each period wrap it drives the
// core's H_on / L_on / DeadTime words. It also handles the soft-start ramp, the
// soft-stop ramp and the latched fault shutdown.
module hr_dpwm_seq #(
    parameter int DE_bits   = 6,
    parameter int Dc_length = 13,
    parameter int PERIOD    = 2**Dc_length - 1,
    parameter int DT_MIN    = 16,
    parameter int DT_MAX    = 1023,
    parameter int SS_STEP   = 256
) (
    input  logic                 clk_base,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 fault,
    input  logic                 period_start,
    input  logic [Dc_length-1:0] duty_req,
    input  logic [Dc_length-1:0] dead_req,
    input  logic                 req_valid,
    output logic                 req_ready,
    output logic [Dc_length-1:0] H_on,
    output logic [Dc_length-1:0] L_on,
    output logic [Dc_length-1:0] DeadTime,
    output logic                 cfg_strobe,
    output logic [1:0]           state,
    output logic                 fault_latched
);
    localparam int W  = Dc_length;
    localparam int WX = Dc_length + 2;   // headroom so 2*dead and sums never wrap
    localparam logic [WX-1:0] PERIOD_X = WX'(PERIOD);
    localparam logic [W-1:0]  DT_MIN_W = W'(DT_MIN);
    localparam logic [W-1:0]  DT_MAX_W = W'(DT_MAX);
    localparam logic [W-1:0]  SS_W     = W'(SS_STEP);
    localparam logic [WX-1:0] SS_X     = WX'(SS_STEP);

    // The fine delay bits must leave a coarse counter field. Dead time must also fit twice into a period.
    if (DE_bits >= Dc_length || 2 * DT_MAX >= PERIOD) begin : g_bad_cfg
        $error("hr_dpwm_seq: inconsistent DE_bits / DT_MAX for Dc_length");
    end

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_SOFT_START = 2'd1,
        S_RUN        = 2'd2,
        S_SOFT_STOP  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   h_q, h_d, l_q, l_d, dt_q, dt_d;
    logic           strobe_q, strobe_d, flt_q, flt_d;
    logic           full_q, full_d;
    logic [W-1:0]   sduty_q, sduty_d, sdead_q, sdead_d;
    logic [W-1:0]   tgt_h_q, tgt_h_d, tgt_dt_q, tgt_dt_d;

    logic           accept, transfer, up_done;
    logic [W-1:0]   dead_c, duty_c, tgt_h_eff, tgt_dt_eff, h_up, h_dn;
    logic [WX-1:0]  lim_x, up_x;

    // Low-side on-time fills what is left of the period after both dead bands.
    function automatic logic [W-1:0] l_of(input logic [W-1:0] h, input logic [W-1:0] dt);
        logic [WX-1:0] lx;
        lx = PERIOD_X - (WX'(dt) << 1) - WX'(h);
        return (lx[WX-1:W] != '0) ? '0 : lx[W-1:0];
    endfunction

    assign req_ready = !full_q && !flt_q;
    assign accept    = req_valid && req_ready;
    assign transfer  = period_start && full_q;

    // Clamp the shadowed request into a legal target, and build the ramp candidates.
    always_comb begin
        dead_c = sdead_q;
        if (sdead_q < DT_MIN_W)
            dead_c = DT_MIN_W;
        else if (sdead_q > DT_MAX_W)
            dead_c = DT_MAX_W;
        lim_x      = PERIOD_X - (WX'(dead_c) << 1);
        duty_c     = (WX'(sduty_q) > lim_x) ? lim_x[W-1:0] : sduty_q;
        tgt_h_eff  = transfer ? duty_c : tgt_h_q;
        tgt_dt_eff = transfer ? dead_c : tgt_dt_q;
        up_x       = WX'(h_q) + SS_X;
        up_done    = up_x >= WX'(tgt_h_eff);
        h_up       = up_done ? tgt_h_eff : up_x[W-1:0];
        h_dn       = (h_q > SS_W) ? h_q - SS_W : '0;
    end

    // State register
    always_ff @(posedge clk_base) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next state: enable acts on any cycle, ramp completion only at a period wrap
    always_comb begin
        state_d = state_q;
        if (fault) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:       if (enable && !flt_q) state_d = S_SOFT_START;
                S_SOFT_START: if (!enable) state_d = S_SOFT_STOP;
                              else if (period_start && up_done) state_d = S_RUN;
                S_RUN:        if (!enable) state_d = S_SOFT_STOP;
                S_SOFT_STOP:  if (enable) state_d = S_SOFT_START;
                              else if (period_start && h_dn == '0) state_d = S_IDLE;
                default:      state_d = S_IDLE;
            endcase
        end
    end

    // Output words: fault forces a safe load at once, otherwise load once per period
    always_comb begin
        h_d      = h_q;
        l_d      = l_q;
        dt_d     = dt_q;
        strobe_d = 1'b0;
        if (fault) begin
            h_d      = '0;
            l_d      = '0;
            dt_d     = DT_MIN_W;
            strobe_d = 1'b1;
        end else if (period_start) begin
            strobe_d = 1'b1;
            case (state_q)
                S_SOFT_START: begin
                    h_d  = h_up;
                    dt_d = tgt_dt_eff;
                    l_d  = l_of(h_up, tgt_dt_eff);
                end
                S_RUN: begin
                    h_d  = tgt_h_eff;
                    dt_d = tgt_dt_eff;
                    l_d  = l_of(tgt_h_eff, tgt_dt_eff);
                end
                S_SOFT_STOP: begin
                    h_d = h_dn;
                    if (h_dn == '0) begin
                        l_d  = '0;
                        dt_d = DT_MIN_W;
                    end else begin
                        l_d = l_of(h_dn, dt_q);
                    end
                end
                default: begin
                    h_d  = '0;
                    l_d  = '0;
                    dt_d = DT_MIN_W;
                end
            endcase
        end
    end

    // Shadow, target and fault latch next state. Targets survive a fault, but the shadow does not.
    always_comb begin
        full_d   = full_q;
        sduty_d  = sduty_q;
        sdead_d  = sdead_q;
        tgt_h_d  = tgt_h_q;
        tgt_dt_d = tgt_dt_q;
        flt_d    = fault || (flt_q && enable);
        if (fault) begin
            full_d = 1'b0;
        end else if (transfer) begin
            full_d   = 1'b0;
            tgt_h_d  = duty_c;
            tgt_dt_d = dead_c;
        end else if (accept) begin
            full_d  = 1'b1;
            sduty_d = duty_req;
            sdead_d = dead_req;
        end
    end

    // Datapath, shadow and flag registers
    always_ff @(posedge clk_base) begin
        if (rst) begin
            h_q      <= '0;
            l_q      <= '0;
            dt_q     <= DT_MIN_W;
            strobe_q <= 1'b0;
            flt_q    <= 1'b0;
            full_q   <= 1'b0;
            sduty_q  <= '0;
            sdead_q  <= '0;
            tgt_h_q  <= '0;
            tgt_dt_q <= DT_MIN_W;
        end else begin
            h_q      <= h_d;
            l_q      <= l_d;
            dt_q     <= dt_d;
            strobe_q <= strobe_d;
            flt_q    <= flt_d;
            full_q   <= full_d;
            sduty_q  <= sduty_d;
            sdead_q  <= sdead_d;
            tgt_h_q  <= tgt_h_d;
            tgt_dt_q <= tgt_dt_d;
        end
    end

    assign H_on          = h_q;
    assign L_on          = l_q;
    assign DeadTime      = dt_q;
    assign cfg_strobe    = strobe_q;
    assign state         = state_q;
    assign fault_latched = flt_q;
endmodule

// File: tb/tb_hr_dpwm_seq.sv
// Bench for hr_dpwm_seq: directed scenarios followed by a random run.
// Every edge is compared against a cycle-level behavioural model.
module tb_hr_dpwm_seq;
    localparam int P   = 8191;
    localparam int DMN = 16;
    localparam int DMX = 1023;
    localparam int SS  = 256;

    logic        clk_base = 1'b0;
    logic        rst = 1'b0, enable = 1'b0, fault = 1'b0, period_start = 1'b0;
    logic [12:0] duty_req = '0, dead_req = '0;
    logic        req_valid = 1'b0;
    logic        req_ready, cfg_strobe, fault_latched;
    logic [12:0] H_on, L_on, DeadTime;
    logic [1:0]  state;

    int n_chk = 0, n_fail = 0;

    // Model state
    int m_st = 0, m_h = 0, m_l = 0, m_dt = DMN, m_th = 0, m_tdt = DMN;
    int m_sduty = 0, m_sdead = 0;
    bit m_stb = 0, m_flt = 0, m_full = 0;

    hr_dpwm_seq dut (
        .clk_base(clk_base), .rst(rst), .enable(enable), .fault(fault),
        .period_start(period_start), .duty_req(duty_req), .dead_req(dead_req),
        .req_valid(req_valid), .req_ready(req_ready), .H_on(H_on), .L_on(L_on),
        .DeadTime(DeadTime), .cfg_strobe(cfg_strobe), .state(state),
        .fault_latched(fault_latched)
    );

    always #5 clk_base = ~clk_base;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Behavioural model of one clock edge, using the inputs present at that edge.
    task automatic model_edge();
        int  old_st, nh;
        bit  old_flt, acc, reach;
        if (rst) begin
            m_st = 0; m_h = 0; m_l = 0; m_dt = DMN; m_stb = 0; m_flt = 0;
            m_full = 0; m_th = 0; m_tdt = DMN;
            return;
        end
        if (fault) begin
            m_st = 0; m_h = 0; m_l = 0; m_dt = DMN; m_stb = 1; m_flt = 1; m_full = 0;
            return;
        end
        old_st  = m_st;
        old_flt = m_flt;
        acc     = req_valid && !m_full && !m_flt;
        m_flt   = m_flt && enable;
        m_stb   = period_start;
        reach   = 0;
        if (period_start) begin
            if (m_full) begin
                m_tdt  = (m_sdead < DMN) ? DMN : (m_sdead > DMX) ? DMX : m_sdead;
                m_th   = imin(m_sduty, P - 2 * m_tdt);
                m_full = 0;
            end
            case (old_st)
                1: begin
                    nh = imin(m_h + SS, m_th);
                    reach = (nh == m_th);
                    m_h = nh; m_dt = m_tdt; m_l = P - 2 * m_dt - m_h;
                end
                2: begin
                    m_h = m_th; m_dt = m_tdt; m_l = P - 2 * m_dt - m_h;
                end
                3: begin
                    nh = (m_h > SS) ? m_h - SS : 0;
                    if (nh == 0) begin
                        m_h = 0; m_l = 0; m_dt = DMN; reach = 1;
                    end else begin
                        m_h = nh; m_l = P - 2 * m_dt - m_h;
                    end
                end
                default: begin
                    m_h = 0; m_l = 0; m_dt = DMN;
                end
            endcase
        end
        if (acc) begin
            m_full = 1; m_sduty = int'(duty_req); m_sdead = int'(dead_req);
        end
        case (old_st)
            0: if (enable && !old_flt) m_st = 1;
            1: if (!enable) m_st = 3; else if (reach) m_st = 2;
            2: if (!enable) m_st = 3;
            default: if (enable) m_st = 1; else if (reach) m_st = 0;
        endcase
    endtask

    task automatic check_all();
        chk("H_on", 32'(H_on), m_h);
        chk("L_on", 32'(L_on), m_l);
        chk("DeadTime", 32'(DeadTime), m_dt);
        chk("cfg_strobe", 32'(cfg_strobe), 32'(m_stb));
        chk("state", 32'(state), m_st);
        chk("fault_latched", 32'(fault_latched), 32'(m_flt));
        chk("req_ready", 32'(req_ready), 32'(!m_full && !m_flt));
    endtask

    // One edge: update the model, then sample the DUT away from the edge.
    task automatic step();
        @(posedge clk_base);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic pstart();
        period_start = 1'b1;
        step();
        period_start = 1'b0;
    endtask

    task automatic request(input int d, input int t);
        duty_req = 13'(d); dead_req = 13'(t); req_valid = 1'b1;
        step();
        req_valid = 1'b0;
    endtask

    initial begin
        int hexp [5] = '{256, 512, 768, 1000, 1000};
        int lexp [5] = '{7835, 7579, 7323, 7091, 7091};

        // Reset
        @(negedge clk_base);
        rst = 1'b1; step(); rst = 1'b0;
        chk("rst_H", 32'(H_on), 0);
        chk("rst_DT", 32'(DeadTime), DMN);
        chk("rst_ready", 32'(req_ready), 1);
        chk("rst_strobe", 32'(cfg_strobe), 0);

        // Soft-start toward duty 1000 / dead 50
        request(1000, 50);
        chk("hs_busy", 32'(req_ready), 0);
        enable = 1'b1; step();
        chk("idle_to_ss", 32'(state), 1);
        for (int i = 0; i < 5; i++) begin
            pstart();
            chk("ss_H", 32'(H_on), hexp[i]);
            chk("ss_L", 32'(L_on), lexp[i]);
            chk("ss_strobe", 32'(cfg_strobe), 1);
            if (i >= 3) chk("ss_run", 32'(state), 2);
            step(); step();
            chk("ss_strobe_low", 32'(cfg_strobe), 0);
        end

        // Clamps
        request(8191, 5); step(); pstart();
        chk("clamp_dtmin", 32'(DeadTime), 16);
        chk("clamp_H", 32'(H_on), 8159);
        chk("clamp_L", 32'(L_on), 0);
        request(8191, 2000); pstart();
        chk("clamp_dtmax", 32'(DeadTime), 1023);
        chk("clamp_H2", 32'(H_on), 6145);

        // Handshake: a held second request waits for the shadow to drain
        request(1500, 40);
        duty_req = 13'd2000; dead_req = 13'd60; req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hs_hold", 32'(req_ready), 0);
        end
        pstart();
        chk("hs_first", 32'(H_on), 1500);
        chk("hs_ready_again", 32'(req_ready), 1);
        step();
        chk("hs_second_acc", 32'(req_ready), 0);
        req_valid = 1'b0; step();
        pstart();
        chk("hs_second_H", 32'(H_on), 2000);
        chk("hs_second_L", 32'(L_on), 6071);

        // Accept coincident with period_start is deferred one period
        duty_req = 13'd700; dead_req = 13'd30; req_valid = 1'b1;
        pstart(); req_valid = 1'b0;
        chk("coinc_defer", 32'(H_on), 2000);
        step(); pstart();
        chk("coinc_apply", 32'(H_on), 700);

        // Soft-stop from 600
        request(600, 30); pstart();
        chk("stop_base", 32'(H_on), 600);
        enable = 1'b0; step();
        chk("stop_state", 32'(state), 3);
        pstart(); chk("stop_H1", 32'(H_on), 344); chk("stop_L1", 32'(L_on), 7787);
        pstart(); chk("stop_H2", 32'(H_on), 88);
        pstart(); chk("stop_H3", 32'(H_on), 0);
        chk("stop_L3", 32'(L_on), 0);
        chk("stop_idle", 32'(state), 0);

        // Fault in RUN
        enable = 1'b1; step();
        pstart(); pstart(); pstart(); step(); step();
        chk("flt_pre_run", 32'(state), 2);
        fault = 1'b1; step(); fault = 1'b0;
        chk("flt_H", 32'(H_on), 0);
        chk("flt_state", 32'(state), 0);
        chk("flt_latched", 32'(fault_latched), 1);
        chk("flt_ready", 32'(req_ready), 0);
        step(); step(); pstart();
        chk("flt_ignore_en", 32'(state), 0);
        enable = 1'b0; step();
        chk("flt_release", 32'(fault_latched), 0);
        enable = 1'b1; step();
        chk("flt_restart", 32'(state), 1);

        // Reset mid soft-start
        pstart();
        rst = 1'b1; step(); rst = 1'b0;
        chk("rst_mid_H", 32'(H_on), 0);
        chk("rst_mid_state", 32'(state), 0);
        chk("rst_mid_ready", 32'(req_ready), 1);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            period_start = ($urandom_range(5) == 0);
            if ($urandom_range(39) == 0) enable = ~enable;
            fault     = ($urandom_range(79) == 0);
            rst       = ($urandom_range(199) == 0);
            req_valid = $urandom_range(1) == 1;
            duty_req  = 13'($urandom_range(8191));
            dead_req  = 13'($urandom_range(2047));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
